// File: rtl/updown_counter_ext.sv
// Up/down counter with programmable bounds, load, and wrap/saturate/bounce/one-shot boundary modes.
// Latency: count/dir/tc/done registered, one cycle after the qualifying input; cfg_err combinational.
// Backpressure: none; en gates stepping, cfg_err freezes all state.
module updown_counter_ext #(
    parameter int                     WIDTH   = 8,
    parameter logic [WIDTH-1:0]       RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             down,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] min_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc,
    output logic             done,
    output logic             cfg_err
);

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_BOUNCE  = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

    logic             bounce;
    logic             eff_dir;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] clamped;
    logic             in_range;
    logic [WIDTH-1:0] count_nxt;
    logic             dir_nxt;
    logic             tc_nxt;
    logic             done_nxt;

    // Outside bounce mode the live down input steers the step, so a
    // direction change acts on the very next edge.
    always_comb begin
        cfg_err  = min_val > max_val;
        bounce   = mode == MODE_BOUNCE;
        eff_dir  = bounce ? dir : down;
        term     = eff_dir ? min_val : max_val;
        in_range = (count >= min_val) && (count <= max_val);
        if (load_val < min_val)
            clamped = min_val;
        else if (load_val > max_val)
            clamped = max_val;
        else
            clamped = load_val;
    end

    always_comb begin
        count_nxt = count;
        dir_nxt   = bounce ? dir : down;
        tc_nxt    = 1'b0;
        done_nxt  = done;
        if (cfg_err) begin
            dir_nxt = dir;
        end else if (load) begin
            count_nxt = clamped;
            dir_nxt   = down;
            done_nxt  = 1'b0;
        end else if (en && !done) begin
            if (!in_range) begin
                // Bounds moved under the count: snap to the terminal bound silently.
                count_nxt = term;
            end else if (count != term) begin
                count_nxt = eff_dir ? count - 1'b1 : count + 1'b1;
            end else begin
                tc_nxt = 1'b1;
                case (mode)
                    MODE_WRAP:    count_nxt = eff_dir ? max_val : min_val;
                    MODE_SAT:     count_nxt = count;
                    MODE_BOUNCE: begin
                        dir_nxt = ~dir;
                        if (min_val != max_val)
                            count_nxt = dir ? count + 1'b1 : count - 1'b1;
                    end
                    MODE_ONESHOT: done_nxt = 1'b1;
                    default:      count_nxt = count;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= RST_VAL;
            dir   <= 1'b0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else begin
            count <= count_nxt;
            dir   <= dir_nxt;
            tc    <= tc_nxt;
            done  <= done_nxt;
        end
    end

endmodule
